// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: single pipeline stage with valid/ready handshake on both sides.
//
// Build option: define PIPE_STAGE_SKID_EN to add a skid register (state TWO).
// With it, in_ready comes from a register, which breaks the combinational
// ready path from downstream. Without it, the stage holds at most one beat,
// and in_ready is combinational from out_ready.
//
// Parameters:
//   DATA_W   payload width (1..1024)
//   CLR_VAL  value loaded into data registers on rst/flush
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (priority over flush)
//   flush      synchronous clear of held beats (priority over transfers)
//   in_valid   upstream beat present
//   in_ready   stage can accept a beat this cycle
//   in_data    upstream payload
//   out_valid  downstream beat present
//   out_ready  downstream accepts a beat this cycle
//   out_data   downstream payload, driven from the main register
//   occ        number of beats held (0..2)
module pipe_stage_reg #(
  parameter int unsigned        DATA_W  = 32,
  parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
`else
  typedef enum logic {EMPTY = 1'b0, ONE = 1'b1} state_t;
`endif

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_main;
  logic                w_in_xfer;
  logic                w_out_xfer;
  logic                w_load_main_in;
`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0]   r_skid;
  logic                r_rdy;
  logic                w_load_main_skid;
  logic                w_load_skid;
`endif

`ifdef PIPE_STAGE_SKID_EN
  // Registered "not full" flag. rst/flush gate it combinationally so that
  // in_ready drops in the same cycle they are asserted.
  assign in_ready = r_rdy && !flush && !rst;
`else
  assign in_ready = ((r_state == EMPTY) || out_ready) && !flush && !rst;
`endif

  assign out_valid  = (r_state != EMPTY);
  assign out_data   = r_main;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_load_main_in = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
`endif
    case (r_state)
      EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt    = ONE;
          w_load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_load_main_in = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
        end else if (w_in_xfer) begin
          w_state_nxt = TWO;
          w_load_skid = 1'b1;
`endif
        end else if (w_out_xfer) begin
          w_state_nxt = EMPTY;
        end
      end
`ifdef PIPE_STAGE_SKID_EN
      TWO: begin
        // in_ready is low in TWO, so only a drain can happen here.
        if (w_out_xfer) begin
          w_state_nxt      = ONE;
          w_load_main_skid = 1'b1;
        end
      end
`endif
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    occ = 2'd0;
    case (r_state)
      EMPTY:   occ = 2'd0;
      ONE:     occ = 2'd1;
`ifdef PIPE_STAGE_SKID_EN
      TWO:     occ = 2'd2;
`endif
      default: occ = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state <= EMPTY;
      r_main  <= CLR_VAL;
`ifdef PIPE_STAGE_SKID_EN
      r_skid  <= CLR_VAL;
      r_rdy   <= 1'b1;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_load_main_in) r_main <= in_data;
`ifdef PIPE_STAGE_SKID_EN
      if (w_load_main_skid) r_main <= r_skid;
      if (w_load_skid)      r_skid <= in_data;
      r_rdy <= (w_state_nxt != TWO);
`endif
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg. The stimulus pushes
// each beat it expects to be accepted. A negedge monitor pops a beat and
// compares it on every output transfer. State checks (occ/out_valid/out_data)
// are made 1 ns after the active edge. Define PIPE_STAGE_SKID_EN to also run
// the skid-register sequences.
module tb_pipe_stage_reg;

  localparam logic [31:0] CLR = 32'hC1C1_C1C1;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occ;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] q[$];

  pipe_stage_reg #(.DATA_W(32), .CLR_VAL(CLR)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occ(occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Output-side scoreboard monitor.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1 && flush === 1'b0 && rst === 1'b0) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_beat: got 0x%08h expected no beat", out_data);
      end else begin
        chk("out_beat", out_data, q.pop_front());
      end
    end
  end

  // One clock cycle of stimulus. It is entered 1 ns after a rising edge and
  // returns 1 ns after the next one.
  task automatic step(input logic iv, input logic [31:0] id, input logic ordy,
                      input logic fl, input logic rs, input logic exp_rdy,
                      input string nm);
    in_valid = iv; in_data = id; out_ready = ordy; flush = fl; rst = rs;
    @(negedge clk);
    chk({nm, ".in_ready"}, {31'd0, in_ready}, {31'd0, exp_rdy});
    if (iv && exp_rdy) q.push_back(id);
    @(posedge clk); #1;
    if (fl || rs) q.delete();
  endtask

  task automatic st(input string nm, input logic [1:0] e_occ, input logic e_valid,
                    input logic [31:0] e_data);
    chk({nm, ".occ"}, {30'd0, occ}, {30'd0, e_occ});
    chk({nm, ".out_valid"}, {31'd0, out_valid}, {31'd0, e_valid});
    chk({nm, ".out_data"}, out_data, e_data);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk); #1;

    // Reset, with a beat offered that must be ignored.
    step(1'b1, 32'hEE, 1'b1, 1'b0, 1'b1, 1'b0, "rst0");
    step(1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, "rst1");
    st("reset", 2'd0, 1'b0, CLR);

    // Streaming with out_ready held high: one beat per cycle, latency 1.
    step(1'b1, 32'h1, 1'b1, 1'b0, 1'b0, 1'b1, "s1");
    st("s1", 2'd1, 1'b1, 32'h1);
    step(1'b1, 32'h2, 1'b1, 1'b0, 1'b0, 1'b1, "s2");
    st("s2", 2'd1, 1'b1, 32'h2);
    step(1'b1, 32'h3, 1'b1, 1'b0, 1'b0, 1'b1, "s3");
    st("s3", 2'd1, 1'b1, 32'h3);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, "drain");
    st("empty_hold", 2'd0, 1'b0, 32'h3);

    // Backpressure: the output stays stable for 5 stalled cycles.
    step(1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 1'b1, "bp_in");
    st("bp_in", 2'd1, 1'b1, 32'h55);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, SKID, "bp_hold");
      st("bp_hold", 2'd1, 1'b1, 32'h55);
    end
`ifndef PIPE_STAGE_SKID_EN
    // A full single-entry stage cannot accept without out_ready.
    step(1'b1, 32'h66, 1'b0, 1'b0, 1'b0, 1'b0, "ns_block");
    st("ns_block", 2'd1, 1'b1, 32'h55);
`endif
    step(1'b1, 32'h66, 1'b1, 1'b0, 1'b0, 1'b1, "passthru");
    st("passthru", 2'd1, 1'b1, 32'h66);

    // Flush with a beat offered: the beat is dropped and the stage is cleared.
`ifdef PIPE_STAGE_SKID_EN
    step(1'b1, 32'hB1, 1'b0, 1'b0, 1'b0, 1'b1, "fill2");
    st("fill2", 2'd2, 1'b1, 32'h66);
`endif
    step(1'b1, 32'h77, 1'b1, 1'b1, 1'b0, 1'b0, "flush");
    st("flush", 2'd0, 1'b0, CLR);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, "post_flush");
    st("post_flush", 2'd0, 1'b0, CLR);

    // rst and flush together, then the first beat afterwards.
    step(1'b1, 32'h12, 1'b0, 1'b0, 1'b0, 1'b1, "pre_rst");
    st("pre_rst", 2'd1, 1'b1, 32'h12);
    step(1'b1, 32'h99, 1'b1, 1'b1, 1'b1, 1'b0, "rst_flush");
    st("rst_flush", 2'd0, 1'b0, CLR);
    step(1'b1, 32'h9, 1'b0, 1'b0, 1'b0, 1'b1, "after_rst");
    st("after_rst", 2'd1, 1'b1, 32'h9);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, "drain9");
    st("drain9", 2'd0, 1'b0, 32'h9);

`ifdef PIPE_STAGE_SKID_EN
    // Skid: the stage fills to two beats, then drains in order.
    step(1'b1, 32'hA, 1'b0, 1'b0, 1'b0, 1'b1, "skA");
    st("skA", 2'd1, 1'b1, 32'hA);
    step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0, 1'b1, "skB");
    st("skB", 2'd2, 1'b1, 32'hA);
    chk("skB.in_ready_full", {31'd0, in_ready}, 32'd0);
    step(1'b1, 32'hC, 1'b1, 1'b0, 1'b0, 1'b0, "skC_blocked");
    st("skC_blocked", 2'd1, 1'b1, 32'hB);
    step(1'b1, 32'hC, 1'b1, 1'b0, 1'b0, 1'b1, "skC");
    st("skC", 2'd1, 1'b1, 32'hC);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, "sk_drain");
    st("sk_drain", 2'd0, 1'b0, 32'hC);
`endif

    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, "idle");
    chk("scoreboard_left", q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
